// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - two-road intersection phase sequencer with an optional pedestrian walk phase
// Counter and state advance only on tick; light outputs are registered and decoded from the next state.
module traffic_sequencer #(
  parameter int T_MAIN_GREEN = 11,
  parameter int T_YELLOW     = 2,
  parameter int T_ALL_RED    = 2,
  parameter int T_SIDE_GREEN = 11,
  parameter int T_WALK       = 10,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ped_req,
  output logic [CNT_W-1:0] counter,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic             ped_pending,
  output logic             phase_change
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] B1 = CNT_W'(T_MAIN_GREEN);
  localparam logic [CNT_W-1:0] B2 = CNT_W'(T_MAIN_GREEN + T_YELLOW);
  localparam logic [CNT_W-1:0] B3 = CNT_W'(T_MAIN_GREEN + T_YELLOW + T_ALL_RED);
  localparam logic [CNT_W-1:0] B4 = CNT_W'(T_MAIN_GREEN + T_YELLOW + T_ALL_RED + T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] B5 = CNT_W'(T_MAIN_GREEN + 2 * T_YELLOW + T_ALL_RED + T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] B6 = CNT_W'(T_MAIN_GREEN + 2 * T_YELLOW + 2 * T_ALL_RED + T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] B7 = CNT_W'(T_MAIN_GREEN + 2 * T_YELLOW + 2 * T_ALL_RED + T_SIDE_GREEN + T_WALK);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [2:0]       main_light_q, main_light_d;
  logic [2:0]       side_light_q, side_light_d;
  logic             walk_q, walk_d;
  logic             ped_pending_q, ped_pending_d;
  logic             phase_change_q, phase_change_d;
  logic [CNT_W-1:0] next_cnt;
  logic             legal;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    next_cnt  = counter_q + 1'b1;

    case (state_q)
      MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN,
      SIDE_YELLOW, ALL_RED_B, PED_WALK: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase

    if (!legal) begin
      state_d   = MAIN_GREEN;
      counter_d = '0;
    end else if (tick) begin
      counter_d = next_cnt;
      if (next_cnt == B1) begin
        state_d = MAIN_YELLOW;
      end else if (next_cnt == B2) begin
        state_d = ALL_RED_A;
      end else if (next_cnt == B3) begin
        state_d = SIDE_GREEN;
      end else if (next_cnt == B4) begin
        state_d = SIDE_YELLOW;
      end else if (next_cnt == B5) begin
        state_d = ALL_RED_B;
      end else if (next_cnt == B6) begin
        // A request arriving on this very cycle still earns the walk.
        if (ped_pending_q || ped_req) begin
          state_d   = PED_WALK;
          counter_d = B6;
        end else begin
          state_d   = MAIN_GREEN;
          counter_d = '0;
        end
      end else if (next_cnt == B7 && state_q == PED_WALK) begin
        state_d   = MAIN_GREEN;
        counter_d = '0;
      end
    end

    ped_pending_d = ped_pending_q;
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && state_q != PED_WALK) begin
      ped_pending_d = 1'b1;
    end

    phase_change_d = (state_d != state_q) || !legal;

    main_light_d = GREEN;
    side_light_d = RED;
    walk_d       = 1'b0;
    case (state_d)
      MAIN_GREEN:  begin main_light_d = GREEN;  side_light_d = RED;    end
      MAIN_YELLOW: begin main_light_d = YELLOW; side_light_d = RED;    end
      ALL_RED_A:   begin main_light_d = RED;    side_light_d = RED;    end
      SIDE_GREEN:  begin main_light_d = RED;    side_light_d = GREEN;  end
      SIDE_YELLOW: begin main_light_d = RED;    side_light_d = YELLOW; end
      ALL_RED_B:   begin main_light_d = RED;    side_light_d = RED;    end
      PED_WALK:    begin main_light_d = RED;    side_light_d = RED;    walk_d = 1'b1; end
      default:     begin main_light_d = GREEN;  side_light_d = RED;    end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= MAIN_GREEN;
      counter_q      <= '0;
      main_light_q   <= GREEN;
      side_light_q   <= RED;
      walk_q         <= 1'b0;
      ped_pending_q  <= 1'b0;
      phase_change_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      main_light_q   <= main_light_d;
      side_light_q   <= side_light_d;
      walk_q         <= walk_d;
      ped_pending_q  <= ped_pending_d;
      phase_change_q <= phase_change_d;
    end
  end

  assign counter      = counter_q;
  assign main_light   = main_light_q;
  assign side_light   = side_light_q;
  assign walk         = walk_q;
  assign ped_pending  = ped_pending_q;
  assign phase_change = phase_change_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - directed bench for traffic_sequencer with default timing parameters
module tb_traffic_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ped_req;
  logic [5:0] counter;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_pending;
  logic       phase_change;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .ped_req      (ped_req),
    .counter      (counter),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk         (walk),
    .ped_pending  (ped_pending),
    .phase_change (phase_change)
  );

  // Expected light for a given counter value outside of a walk phase (boundaries 11,13,15,26,28,30).
  function automatic logic [2:0] exp_main(int c);
    if (c < 11)      return 3'b001;
    else if (c < 13) return 3'b010;
    else             return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(int c);
    if (c < 15)      return 3'b100;
    else if (c < 26) return 3'b001;
    else if (c < 28) return 3'b010;
    else             return 3'b100;
  endfunction

  task automatic do_reset;
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_tick;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    vectors++; if (counter !== 6'd0) begin miscompares++; $display("FAIL rst_counter got %0d want 0", counter); end
    vectors++; if (main_light !== 3'b001) begin miscompares++; $display("FAIL rst_main got %b want 001", main_light); end
    vectors++; if (side_light !== 3'b100) begin miscompares++; $display("FAIL rst_side got %b want 100", side_light); end
    vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL rst_walk got %b want 0", walk); end
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL rst_pending got %b want 0", ped_pending); end
    vectors++; if (phase_change !== 1'b0) begin miscompares++; $display("FAIL rst_phase_change got %b want 0", phase_change); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal_cycle;
    int pulses = 0;
    int c;
    logic exp_pc;
    do_reset;
    for (int i = 1; i <= 30; i++) begin
      step_tick;
      c = i % 30;
      exp_pc = (c == 0 || c == 11 || c == 13 || c == 15 || c == 26 || c == 28);
      if (phase_change === 1'b1) pulses++;
      vectors++; if (counter !== 6'(c)) begin miscompares++; $display("FAIL cyc_counter tick=%0d got %0d want %0d", i, counter, c); end
      vectors++; if (main_light !== exp_main(c)) begin miscompares++; $display("FAIL cyc_main cnt=%0d got %b want %b", c, main_light, exp_main(c)); end
      vectors++; if (side_light !== exp_side(c)) begin miscompares++; $display("FAIL cyc_side cnt=%0d got %b want %b", c, side_light, exp_side(c)); end
      vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL cyc_walk cnt=%0d got %b want 0", c, walk); end
      vectors++; if (phase_change !== exp_pc) begin miscompares++; $display("FAIL cyc_pc cnt=%0d got %b want %b", c, phase_change, exp_pc); end
      @(negedge clk);
      vectors++; if (phase_change !== 1'b0) begin miscompares++; $display("FAIL cyc_pc_width cnt=%0d got %b want 0", c, phase_change); end
    end
    vectors++; if (pulses !== 6) begin miscompares++; $display("FAIL cyc_pulse_count got %0d want 6", pulses); end
  endtask

  task automatic test_ped_walk;
    do_reset;
    for (int i = 1; i <= 5; i++) step_tick;
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    vectors++; if (ped_pending !== 1'b1) begin miscompares++; $display("FAIL ped_latch got %b want 1", ped_pending); end
    for (int i = 6; i <= 29; i++) begin
      step_tick;
      vectors++; if (ped_pending !== 1'b1) begin miscompares++; $display("FAIL ped_hold cnt=%0d got %b want 1", i, ped_pending); end
    end
    vectors++; if (counter !== 6'd29) begin miscompares++; $display("FAIL ped_pre_cnt got %0d want 29", counter); end
    step_tick;
    vectors++; if (counter !== 6'd30) begin miscompares++; $display("FAIL ped_enter_cnt got %0d want 30", counter); end
    vectors++; if (walk !== 1'b1) begin miscompares++; $display("FAIL ped_enter_walk got %b want 1", walk); end
    vectors++; if (main_light !== 3'b100) begin miscompares++; $display("FAIL ped_main got %b want 100", main_light); end
    vectors++; if (side_light !== 3'b100) begin miscompares++; $display("FAIL ped_side got %b want 100", side_light); end
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL ped_clear got %b want 0", ped_pending); end
    vectors++; if (phase_change !== 1'b1) begin miscompares++; $display("FAIL ped_pc got %b want 1", phase_change); end
    for (int i = 31; i <= 39; i++) begin
      step_tick;
      vectors++; if (counter !== 6'(i)) begin miscompares++; $display("FAIL ped_walk_cnt got %0d want %0d", counter, i); end
      vectors++; if (walk !== 1'b1) begin miscompares++; $display("FAIL ped_walk_lamp cnt=%0d got %b want 1", i, walk); end
    end
    step_tick;
    vectors++; if (counter !== 6'd0) begin miscompares++; $display("FAIL ped_exit_cnt got %0d want 0", counter); end
    vectors++; if (main_light !== 3'b001) begin miscompares++; $display("FAIL ped_exit_main got %b want 001", main_light); end
    vectors++; if (side_light !== 3'b100) begin miscompares++; $display("FAIL ped_exit_side got %b want 100", side_light); end
    vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL ped_exit_walk got %b want 0", walk); end
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL ped_exit_pending got %b want 0", ped_pending); end
  endtask

  task automatic test_ped_same_cycle;
    do_reset;
    for (int i = 1; i <= 29; i++) step_tick;
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL same_pre_pending got %b want 0", ped_pending); end
    @(negedge clk) begin tick = 1'b1; ped_req = 1'b1; end
    @(negedge clk) begin tick = 1'b0; ped_req = 1'b0; end
    vectors++; if (counter !== 6'd30) begin miscompares++; $display("FAIL same_cnt got %0d want 30", counter); end
    vectors++; if (walk !== 1'b1) begin miscompares++; $display("FAIL same_walk got %b want 1", walk); end
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL same_pending got %b want 0", ped_pending); end
    @(negedge clk);
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL same_pending_late got %b want 0", ped_pending); end
    for (int i = 31; i <= 40; i++) step_tick;
    vectors++; if (counter !== 6'd0) begin miscompares++; $display("FAIL same_exit_cnt got %0d want 0", counter); end
    vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL same_exit_walk got %b want 0", walk); end
  endtask

  task automatic test_ped_held_in_walk;
    do_reset;
    for (int i = 1; i <= 29; i++) step_tick;
    @(negedge clk) begin tick = 1'b1; ped_req = 1'b1; end
    @(negedge clk) tick = 1'b0;
    vectors++; if (walk !== 1'b1) begin miscompares++; $display("FAIL held_enter_walk got %b want 1", walk); end
    for (int i = 31; i <= 39; i++) begin
      step_tick;
      vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL held_pending cnt=%0d got %b want 0", i, ped_pending); end
    end
    ped_req = 1'b0;
    step_tick;
    vectors++; if (counter !== 6'd0) begin miscompares++; $display("FAIL held_exit_cnt got %0d want 0", counter); end
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL held_exit_pending got %b want 0", ped_pending); end
    for (int i = 1; i <= 30; i++) begin
      step_tick;
      vectors++; if (counter !== 6'(i % 30)) begin miscompares++; $display("FAIL held_next_cnt got %0d want %0d", counter, i % 30); end
      vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL held_next_walk cnt=%0d got %b want 0", i % 30, walk); end
    end
  endtask

  task automatic test_reset_in_walk;
    do_reset;
    for (int i = 1; i <= 29; i++) step_tick;
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    for (int i = 30; i <= 34; i++) step_tick;
    vectors++; if (counter !== 6'd34 || walk !== 1'b1) begin miscompares++; $display("FAIL arst_pre got cnt=%0d walk=%b want cnt=34 walk=1", counter, walk); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (counter !== 6'd0) begin miscompares++; $display("FAIL arst_counter got %0d want 0", counter); end
    vectors++; if (main_light !== 3'b001) begin miscompares++; $display("FAIL arst_main got %b want 001", main_light); end
    vectors++; if (side_light !== 3'b100) begin miscompares++; $display("FAIL arst_side got %b want 100", side_light); end
    vectors++; if (walk !== 1'b0) begin miscompares++; $display("FAIL arst_walk got %b want 0", walk); end
    vectors++; if (phase_change !== 1'b0) begin miscompares++; $display("FAIL arst_pc got %b want 0", phase_change); end
    @(negedge clk) reset = 1'b0;
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    vectors++; if (ped_pending !== 1'b1) begin miscompares++; $display("FAIL arst_relatch got %b want 1", ped_pending); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (ped_pending !== 1'b0) begin miscompares++; $display("FAIL arst_discard got %b want 0", ped_pending); end
    @(negedge clk) reset = 1'b0;
    step_tick;
    vectors++; if (counter !== 6'd1) begin miscompares++; $display("FAIL arst_restart_cnt got %0d want 1", counter); end
    vectors++; if (main_light !== 3'b001) begin miscompares++; $display("FAIL arst_restart_main got %b want 001", main_light); end
  endtask

  task automatic test_tick_hold;
    do_reset;
    for (int i = 1; i <= 12; i++) step_tick;
    vectors++; if (counter !== 6'd12 || main_light !== 3'b010) begin miscompares++; $display("FAIL hold_pre got cnt=%0d main=%b want cnt=12 main=010", counter, main_light); end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 50) ped_req = 1'b1;
      if (k == 51) ped_req = 1'b0;
      vectors++;
      if (counter !== 6'd12 || main_light !== 3'b010 || side_light !== 3'b100 || walk !== 1'b0 || phase_change !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_state k=%0d got cnt=%0d main=%b side=%b walk=%b pc=%b want cnt=12 main=010 side=100 walk=0 pc=0",
                 k, counter, main_light, side_light, walk, phase_change);
      end
    end
    vectors++; if (ped_pending !== 1'b1) begin miscompares++; $display("FAIL hold_pending got %b want 1", ped_pending); end
    step_tick;
    vectors++; if (counter !== 6'd13 || main_light !== 3'b100) begin miscompares++; $display("FAIL hold_resume got cnt=%0d main=%b want cnt=13 main=100", counter, main_light); end
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    test_reset;
    test_normal_cycle;
    test_ped_walk;
    test_ped_same_cycle;
    test_ped_held_in_walk;
    test_reset_in_walk;
    test_tick_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Phase sequencer for the two-road intersection: it owns the 6-bit phase counter and walks the main road, side road and pedestrian crossing through their light phases. It serves optional pedestrian requests with a walk phase appended to the normal cycle. It advances on an external one-pulse-per-second tick and drives the light outputs and a phase-change strobe to the rest of the design.

## Interface
- T_MAIN_GREEN, default 11: main-road green duration, in ticks.
- T_YELLOW, default 2: yellow duration for either road, in ticks.
- T_ALL_RED, default 2: all-red clearance duration, in ticks.
- T_SIDE_GREEN, default 11: side-road green duration, in ticks.
- T_WALK, default 10: pedestrian walk duration, in ticks.
- CNT_W, default 6: counter width. The full cycle length, 2*(T_YELLOW+T_ALL_RED)+T_MAIN_GREEN+T_SIDE_GREEN+T_WALK, must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk-wide timebase enable; the counter and state change only on cycles where tick=1.
- ped_req  in  1  pedestrian button, already synchronized; sampled every clk.
- counter  out  CNT_W  phase counter, 0 .. cycle end.
- main_light  out  3  one-hot {red, yellow, green}.
- side_light  out  3  one-hot {red, yellow, green}.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  pedestrian request latched and not yet served.
- phase_change  out  1  one-clk pulse on the cycle after each state transition.

## Operation
- Boundaries, all computed from the parameters:
  - B1=T_MAIN_GREEN
  - B2=B1+T_YELLOW
  - B3=B2+T_ALL_RED
  - B4=B3+T_SIDE_GREEN
  - B5=B4+T_YELLOW
  - B6=B5+T_ALL_RED
  - B7=B6+T_WALK
  - With defaults these are 11, 13, 15, 26, 28, 30, 40.
- States and outputs (main / side / walk):
  - MAIN_GREEN: G / R / 0
  - MAIN_YELLOW: Y / R / 0
  - ALL_RED_A: R / R / 0
  - SIDE_GREEN: R / G / 0
  - SIDE_YELLOW: R / Y / 0
  - ALL_RED_B: R / R / 0
  - PED_WALK: R / R / 1
- On tick, let n = counter+1:
  - n==B1: MAIN_GREEN→MAIN_YELLOW
  - n==B2: →ALL_RED_A
  - n==B3: →SIDE_GREEN
  - n==B4: →SIDE_YELLOW
  - n==B5: →ALL_RED_B
  - n==B6 with (ped_pending | ped_req)=1: →PED_WALK, counter←B6.
  - n==B6 otherwise: →MAIN_GREEN, counter←0.
  - n==B7 in PED_WALK: →MAIN_GREEN, counter←0.
  - Any other n: counter←n, state unchanged.
- Pedestrian latch:
  - ped_pending←1 on any clk with ped_req=1 while state≠PED_WALK.
  - ped_pending←0 on the transition into PED_WALK.
  - ped_req during PED_WALK is ignored.
  - ped_req is only ever served at B6, never by shortening any phase.
- Outputs are registered, decoded from the state register. Exactly one bit of each light vector is set at all times.
- Illegal or unreachable state encodings recover to MAIN_GREEN with counter 0 on the next clk.
- Reset values: state MAIN_GREEN, counter 0, main_light 3'b001, side_light 3'b100, walk 0, ped_pending 0, phase_change 0.

## Timing
- State change latency: outputs change on the clk edge that samples tick=1 at the boundary; no extra clk of delay.
- phase_change is high for exactly one clk, the cycle after that edge. It stays low when tick advances the counter without a transition.
- tick=0: all registers hold, except ped_pending, which still latches.
- ped_req and tick both high in the cycle where n==B6: the walk is taken. ped_pending never becomes visible as 1 in that case.
- ped_req arriving one clk after the B6 edge: it is latched and served in the next cycle.
- Reset asserted mid-phase, including during PED_WALK: all outputs take their reset values immediately and asynchronously. A pending request is discarded.
- Counter wrap: the counter never exceeds B7−1 (walk) or B6−1 (no walk). There is no modular overflow.

## Test plan
- Reset, then 30 ticks with ped_req=0:
  - main_light goes 001→010 at counter 11, →100 at 13.
  - side_light goes →001 at 15, →010 at 26, →100 at 28.
  - counter wraps 29→0.
  - 6 phase_change pulses are seen.
- ped_req pulse at counter 5:
  - ped_pending=1 until the tick at counter 29.
  - Then state goes to PED_WALK with walk=1, both lights 100, counter 30..39.
  - After tick 40: counter 0, MAIN_GREEN, ped_pending=0.
- ped_req and tick both high at counter 29: PED_WALK is entered on that edge and ped_pending stays 0.
- ped_req held during PED_WALK: ped_pending stays 0, and the next cycle wraps at 30 with no walk.
- Reset asserted at counter 34 in PED_WALK: outputs go to their reset values without waiting for a clk edge. After release, the sequence restarts from 0.
- tick held low for 100 clks at counter 12: all outputs hold, phase_change=0, and ped_req still sets ped_pending.
